regfile_access_ctrl: RTL and testbench

Initiator-side controller for the 8x8 register file: drives RA1/RA2 from issued instructions, captures RD1/RD2 into an operand output register, and drives WE/WA/WD from the writeback channel. Tracks in-flight destination registers in a scoreboard, stalls RAW and WAW hazards, and forwards same-cycle writeback data. Sits between decode (REQ channel), execute (OP channel) and writeback (WB channel).

---
 rtl/regfile_pkg.sv | 15 +
 rtl/rf_scoreboard.sv | 50 +++++
 rtl/regfile_access_ctrl.sv | 107 ++++++++++
 tb/tb_regfile_access_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and output-slot state encoding for the register-file access controller.
package regfile_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned STALL_W  = 8;
    localparam int unsigned NREG     = 8;
    localparam int unsigned REG_ZERO = 0;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy bits for in-flight destination registers; lookups see a same-cycle writeback as already retired.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [AW-1:0] addr_c,
    output logic          eff_a,
    output logic          eff_b,
    output logic          eff_c,
    output logic          busy_clr
);

    localparam int unsigned N = 1 << AW;

    logic [N-1:0] busy;
    logic [N-1:0] busy_eff;
    logic [N-1:0] busy_nxt;

    always_comb begin
        busy_eff = busy;
        if (clr_en) busy_eff[clr_addr] = 1'b0;
    end

    // Clear is folded into busy_eff first, so a set to the same register wins.
    always_comb begin
        busy_nxt = busy_eff;
        if (set_en) busy_nxt[set_addr] = 1'b1;
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    assign eff_a    = busy_eff[addr_a];
    assign eff_b    = busy_eff[addr_b];
    assign eff_c    = busy_eff[addr_c];
    assign busy_clr = busy[clr_addr];

endmodule

// File: rtl/regfile_access_ctrl.sv
// Issue-side controller for the 8x8 register file: operand capture with forwarding,
// RAW/WAW hazard stalls via a busy scoreboard, and writeback port steering.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned DW = DATA_W,
    parameter int unsigned AW = ADDR_W,
    parameter int unsigned CW = STALL_W
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic [AW-1:0] REQ_RS1,
    input  logic [AW-1:0] REQ_RS2,
    input  logic [AW-1:0] REQ_RD,
    input  logic          REQ_WR,
    output logic          OP_VALID,
    input  logic          OP_READY,
    output logic [DW-1:0] OP_A,
    output logic [DW-1:0] OP_B,
    output logic [AW-1:0] OP_RD,
    output logic          OP_WR,
    input  logic          WB_VALID,
    input  logic [AW-1:0] WB_RD,
    input  logic [DW-1:0] WB_DATA,
    output logic [AW-1:0] RF_RA1,
    output logic [AW-1:0] RF_RA2,
    input  logic [DW-1:0] RF_RD1,
    input  logic [DW-1:0] RF_RD2,
    output logic          RF_WE,
    output logic [AW-1:0] RF_WA,
    output logic [DW-1:0] RF_WD,
    output logic          WB_ERR,
    output logic [CW-1:0] STALL_CNT
);

    slot_state_t   state;
    logic          busy_rs1, busy_rs2, busy_rd, busy_wb;
    logic          hazard, slot_free, accept, stall, wb_spurious;
    logic          fwd1, fwd2;
    logic [DW-1:0] opnd_a, opnd_b;

    rf_scoreboard #(.AW(AW)) u_sb (
        .clk      (CLK),
        .rst_n    (RST_N),
        .set_en   (accept && REQ_WR && (REQ_RD != '0)),
        .set_addr (REQ_RD),
        .clr_en   (WB_VALID),
        .clr_addr (WB_RD),
        .addr_a   (REQ_RS1),
        .addr_b   (REQ_RS2),
        .addr_c   (REQ_RD),
        .eff_a    (busy_rs1),
        .eff_b    (busy_rs2),
        .eff_c    (busy_rd),
        .busy_clr (busy_wb)
    );

    assign RF_RA1 = REQ_RS1;
    assign RF_RA2 = REQ_RS2;
    assign RF_WE  = WB_VALID && (WB_RD != '0);
    assign RF_WA  = WB_RD;
    assign RF_WD  = WB_DATA;

    assign OP_VALID    = (state == SLOT_FULL);
    assign slot_free   = !OP_VALID || OP_READY;
    assign hazard      = REQ_VALID && (busy_rs1 || busy_rs2 || (REQ_WR && busy_rd));
    assign REQ_READY   = slot_free && !hazard;
    assign accept      = REQ_VALID && REQ_READY;
    assign stall       = REQ_VALID && slot_free && hazard;
    assign wb_spurious = WB_VALID && (WB_RD != '0) && !busy_wb;

    // Same-cycle writeback bypasses the register file; R0 never forwards.
    always_comb begin
        fwd1   = WB_VALID && (WB_RD == REQ_RS1) && (REQ_RS1 != '0);
        fwd2   = WB_VALID && (WB_RD == REQ_RS2) && (REQ_RS2 != '0);
        opnd_a = fwd1 ? WB_DATA : ((REQ_RS1 == '0) ? '0 : RF_RD1);
        opnd_b = fwd2 ? WB_DATA : ((REQ_RS2 == '0) ? '0 : RF_RD2);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= SLOT_EMPTY;
            OP_A      <= '0;
            OP_B      <= '0;
            OP_RD     <= '0;
            OP_WR     <= 1'b0;
            WB_ERR    <= 1'b0;
            STALL_CNT <= '0;
        end else begin
            case (state)
                SLOT_EMPTY: if (accept) state <= SLOT_FULL;
                SLOT_FULL:  if (!accept && OP_READY) state <= SLOT_EMPTY;
            endcase
            if (accept) begin
                OP_A  <= opnd_a;
                OP_B  <= opnd_b;
                OP_RD <= REQ_RD;
                OP_WR <= REQ_WR;
            end
            if (wb_spurious) WB_ERR <= 1'b1;
            if (stall && (STALL_CNT != '1)) STALL_CNT <= STALL_CNT + CW'(1);
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_access_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic [2:0] REQ_RS1 = '0, REQ_RS2 = '0, REQ_RD = '0;
    logic       REQ_WR = 1'b0;
    logic       OP_VALID;
    logic       OP_READY = 1'b1;
    logic [7:0] OP_A, OP_B;
    logic [2:0] OP_RD;
    logic       OP_WR;
    logic       WB_VALID = 1'b0;
    logic [2:0] WB_RD = '0;
    logic [7:0] WB_DATA = '0;
    logic [2:0] RF_RA1, RF_RA2, RF_WA;
    logic [7:0] RF_RD1, RF_RD2, RF_WD;
    logic       RF_WE;
    logic       WB_ERR;
    logic [7:0] STALL_CNT;

    int checks = 0;
    int errors = 0;

    regfile_access_ctrl #(.DW(8), .AW(3), .CW(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_RS1(REQ_RS1), .REQ_RS2(REQ_RS2), .REQ_RD(REQ_RD), .REQ_WR(REQ_WR),
        .OP_VALID(OP_VALID), .OP_READY(OP_READY),
        .OP_A(OP_A), .OP_B(OP_B), .OP_RD(OP_RD), .OP_WR(OP_WR),
        .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
        .RF_RA1(RF_RA1), .RF_RA2(RF_RA2), .RF_RD1(RF_RD1), .RF_RD2(RF_RD2),
        .RF_WE(RF_WE), .RF_WA(RF_WA), .RF_WD(RF_WD),
        .WB_ERR(WB_ERR), .STALL_CNT(STALL_CNT)
    );

    always #5 CLK = ~CLK;

    // Register file the controller drives; R0 reads as zero.
    logic [7:0] rf_mem [8] = '{default: 8'h00};
    always @(posedge CLK) if (RF_WE) rf_mem[RF_WA] <= RF_WD;
    assign RF_RD1 = (RF_RA1 == 3'd0) ? 8'h00 : rf_mem[RF_RA1];
    assign RF_RD2 = (RF_RA2 == 3'd0) ? 8'h00 : rf_mem[RF_RA2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural register contents, busy set, operand slot, sticky flags.
    bit   [7:0]  m_busy;
    logic [7:0]  m_rf [8] = '{default: 8'h00};
    bit          m_valid, m_wr, m_err;
    logic [7:0]  m_a, m_b;
    logic [2:0]  m_rd;
    int unsigned m_stall;

    function automatic bit in_flight(input logic [2:0] r);
        return m_busy[r] && !(WB_VALID && WB_RD == r);
    endfunction

    function automatic logic [7:0] value_of(input logic [2:0] r);
        if (r == 3'd0) return 8'h00;
        if (WB_VALID && WB_RD == r) return WB_DATA;
        return m_rf[r];
    endfunction

    always @(negedge CLK) begin
        bit hz, fr, rdy, acc;
        logic [7:0] na, nb;
        if (!RST_N) begin
            m_busy = '0; m_valid = 0; m_a = '0; m_b = '0; m_rd = '0;
            m_wr = 0; m_err = 0; m_stall = 0;
        end
        hz  = REQ_VALID && (in_flight(REQ_RS1) || in_flight(REQ_RS2) || (REQ_WR && in_flight(REQ_RD)));
        fr  = !m_valid || OP_READY;
        rdy = fr && !hz;
        chk("req_ready", REQ_READY, rdy);
        chk("op_valid", OP_VALID, m_valid);
        chk("op_a", OP_A, m_a);
        chk("op_b", OP_B, m_b);
        chk("op_rd", OP_RD, m_rd);
        chk("op_wr", OP_WR, m_wr);
        chk("rf_ra1", RF_RA1, REQ_RS1);
        chk("rf_ra2", RF_RA2, REQ_RS2);
        chk("rf_we", RF_WE, WB_VALID && WB_RD != 3'd0);
        chk("rf_wa", RF_WA, WB_RD);
        chk("rf_wd", RF_WD, WB_DATA);
        chk("wb_err", WB_ERR, m_err);
        chk("stall_cnt", STALL_CNT, m_stall);
        chk("busy_vec", dut.u_sb.busy, m_busy);
        if (RST_N) begin
            acc = REQ_VALID && rdy;
            if (REQ_VALID && fr && hz && m_stall < 255) m_stall++;
            if (WB_VALID && WB_RD != 3'd0 && !m_busy[WB_RD]) m_err = 1;
            na = value_of(REQ_RS1);
            nb = value_of(REQ_RS2);
            if (acc) begin
                m_valid = 1; m_a = na; m_b = nb; m_rd = REQ_RD; m_wr = REQ_WR;
            end else if (OP_READY) begin
                m_valid = 0;
            end
            if (WB_VALID) m_busy[WB_RD] = 0;
            if (acc && REQ_WR && REQ_RD != 3'd0) m_busy[REQ_RD] = 1;
        end
        if (WB_VALID && WB_RD != 3'd0) m_rf[WB_RD] = WB_DATA;
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic req(input bit v, input logic [2:0] s1, input logic [2:0] s2,
                       input logic [2:0] d, input bit w);
        REQ_VALID = v; REQ_RS1 = s1; REQ_RS2 = s2; REQ_RD = d; REQ_WR = w;
    endtask

    task automatic wb(input bit v, input logic [2:0] r, input logic [7:0] d);
        WB_VALID = v; WB_RD = r; WB_DATA = d;
    endtask

    initial begin
        int cand[$];
        #1 RST_N = 1'b0;
        // Preload R1..R7 with 0x11*r while the controller is held in reset.
        for (int r = 1; r < 8; r++) begin
            cyc();
            wb(1, 3'(r), 8'(r * 8'h11));
        end
        cyc();
        wb(0, 3'd0, 8'h00);
        #1;
        chk("rst_op_valid", OP_VALID, 1'b0);
        chk("rst_stall", STALL_CNT, 8'h00);
        chk("rst_wb_err", WB_ERR, 1'b0);
        cyc();
        RST_N = 1'b1;

        // Independent issue, then hold under backpressure.
        cyc();
        req(1, 3'd1, 3'd2, 3'd4, 1); OP_READY = 0;
        #1 chk("indep_ready", REQ_READY, 1'b1);
        cyc();
        req(1, 3'd1, 3'd2, 3'd5, 1);
        chk("indep_op_a", OP_A, 8'h11);
        chk("indep_op_b", OP_B, 8'h22);
        chk("indep_busy4", dut.u_sb.busy[4], 1'b1);
        chk("model_op_a", m_a, 8'h11);
        chk("model_busy4", m_busy[4], 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_ready", REQ_READY, 1'b0);
            chk("bp_op_rd", OP_RD, 3'd4);
            chk("bp_op_a", OP_A, 8'h11);
        end
        OP_READY = 1;
        #1 chk("bp_release_ready", REQ_READY, 1'b1);
        cyc();
        chk("no_bubble_valid", OP_VALID, 1'b1);
        chk("no_bubble_rd", OP_RD, 3'd5);

        // RAW stall on R4, released by its writeback with forwarding.
        req(1, 3'd4, 3'd0, 3'd6, 1);
        #1 chk("raw_ready", REQ_READY, 1'b0);
        cyc();
        chk("raw_stall1", STALL_CNT, 8'd1);
        cyc();
        chk("raw_stall2", STALL_CNT, 8'd2);
        wb(1, 3'd4, 8'h5A);
        #1 chk("raw_wb_ready", REQ_READY, 1'b1);
        chk("raw_rf_we", RF_WE, 1'b1);
        cyc();
        chk("fwd_op_a", OP_A, 8'h5A);
        chk("fwd_op_b", OP_B, 8'h00);
        chk("fwd_stall", STALL_CNT, 8'd2);
        chk("fwd_busy4", dut.u_sb.busy[4], 1'b0);
        chk("fwd_busy6", dut.u_sb.busy[6], 1'b1);
        chk("model_fwd_a", m_a, 8'h5A);

        // R0 writeback is dropped and never forwarded.
        req(1, 3'd0, 3'd0, 3'd0, 0);
        wb(1, 3'd0, 8'hFF);
        #1 chk("r0_rf_we", RF_WE, 1'b0);
        cyc();
        chk("r0_op_a", OP_A, 8'h00);
        chk("r0_wb_err", WB_ERR, 1'b0);

        // Writeback to a register that is not in flight.
        req(0, 3'd0, 3'd0, 3'd0, 0);
        wb(1, 3'd3, 8'h77);
        #1 chk("spur_rf_we", RF_WE, 1'b1);
        cyc();
        wb(0, 3'd0, 8'h00);
        chk("spur_wb_err", WB_ERR, 1'b1);
        chk("spur_rf3", rf_mem[3], 8'h77);
        for (int i = 0; i < 3; i++) cyc();
        chk("spur_sticky", WB_ERR, 1'b1);

        // Asynchronous reset with a full slot and R3 in flight.
        req(1, 3'd1, 3'd2, 3'd3, 1); OP_READY = 0;
        cyc();
        req(0, 3'd0, 3'd0, 3'd0, 0);
        chk("pre_rst_valid", OP_VALID, 1'b1);
        chk("pre_rst_busy3", dut.u_sb.busy[3], 1'b1);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_valid", OP_VALID, 1'b0);
        chk("mid_rst_busy", dut.u_sb.busy, 8'h00);
        chk("mid_rst_stall", STALL_CNT, 8'h00);
        chk("mid_rst_err", WB_ERR, 1'b0);
        cyc();
        RST_N = 1'b1; OP_READY = 1;

        // Randomized traffic; writebacks target in-flight registers or R0.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            req(($urandom_range(0, 9) < 7), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
            OP_READY = ($urandom_range(0, 9) < 7);
            cand.delete();
            for (int r = 1; r < 8; r++) if (m_busy[r]) cand.push_back(r);
            if (cand.size() > 0 && $urandom_range(0, 9) < 4)
                wb(1, 3'(cand[$urandom_range(0, cand.size() - 1)]), 8'($urandom));
            else if ($urandom_range(0, 19) == 0)
                wb(1, 3'd0, 8'($urandom));
            else
                wb(0, 3'd0, 8'h00);
        end

        // Stall counter saturation.
        cyc();
        req(0, 3'd0, 3'd0, 3'd0, 0); wb(0, 3'd0, 8'h00); OP_READY = 1;
        RST_N = 1'b0;
        cyc();
        RST_N = 1'b1;
        cyc();
        req(1, 3'd0, 3'd0, 3'd7, 1);
        cyc();
        req(1, 3'd7, 3'd0, 3'd1, 0);
        for (int i = 0; i < 260; i++) cyc();
        chk("sat_stall", STALL_CNT, 8'hFF);
        chk("sat_ready", REQ_READY, 1'b0);
        wb(1, 3'd7, 8'h99);
        cyc();
        req(0, 3'd0, 3'd0, 3'd0, 0); wb(0, 3'd0, 8'h00);
        chk("sat_fwd_a", OP_A, 8'h99);
        chk("sat_hold", STALL_CNT, 8'hFF);
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
